aes_bram_responder: RTL and testbench

- Responder end of the AES engine's BRAM request interface: services word read and word write requests raised on start_read / start_write.
- Drives a single-port synchronous BRAM and returns a one-cycle bram_complete pulse per serviced request.
- Sits between the AES top-level sequencer and the shared BRAM.

---
 rtl/aes_bram_responder.sv | 141 ++++++++++++++
 tb/tb_aes_bram_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_bram_responder.sv
// BRAM responder for the AES sequencer: services held word read/write requests with one complete pulse each.
// Optional build macro AES_BRAM_ALIGN_CHECK_EN rejects misaligned byte addresses with bram_err instead of truncating.
//
// state    | meaning
// IDLE     | waiting for a request; read wins over write
// RD_ISSUE | BRAM enable + address for a read
// RD_WAIT  | counting down BRAM read latency
// WR_ISSUE | BRAM enable + full write strobe
// DONE     | one-cycle bram_complete pulse
// RELEASE  | waits for the serviced request line to drop
module aes_bram_responder #(
    parameter int READ_LATENCY = 2,
    parameter int BRAM_AW      = 12
) (
    input  logic               aes_clk,
    input  logic               aes_rst_n,
    input  logic               aes_start_read,
    input  logic               aes_start_write,
    input  logic [31:0]        aes_bram_addr,
    input  logic [31:0]        aes_bram_write_addr,
    input  logic [31:0]        aes_bram_write_data,
    output logic [31:0]        aes_bram_read_data,
    output logic               bram_complete,
    output logic               bram_err,
    output logic               bram_en,
    output logic [3:0]         bram_we,
    output logic [BRAM_AW-1:0] bram_word_addr,
    output logic [31:0]        bram_wrdata,
    input  logic [31:0]        bram_rddata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        DONE     = 3'd4,
        RELEASE  = 3'd5
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

    state_t             state;
    state_t             state_nxt;
    logic [BRAM_AW-1:0] addr_q;
    logic [31:0]        data_q;
    logic               op_rd_q;
    logic [2:0]         cnt_q;
    logic               req;
    logic [31:0]        cap_addr;
    logic               misaligned;
    logic               serviced_line;
    logic               unused_addr_bits;

    assign req      = aes_start_read | aes_start_write;
    assign cap_addr = aes_start_read ? aes_bram_addr : aes_bram_write_addr;

`ifdef AES_BRAM_ALIGN_CHECK_EN
    assign misaligned = (cap_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign unused_addr_bits = ^{aes_bram_addr[31:BRAM_AW+2], aes_bram_addr[1:0],
                                aes_bram_write_addr[31:BRAM_AW+2], aes_bram_write_addr[1:0]};

    // Only the line that was serviced can release the FSM; the other stays pending.
    assign serviced_line = op_rd_q ? aes_start_read : aes_start_write;

    assign bram_word_addr = addr_q;
    assign bram_wrdata    = data_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (misaligned)
                        state_nxt = DONE;
                    else if (aes_start_read)
                        state_nxt = RD_ISSUE;
                    else
                        state_nxt = WR_ISSUE;
                end
            end
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (cnt_q == 3'd0)
                    state_nxt = DONE;
            end
            WR_ISSUE: state_nxt = DONE;
            DONE:     state_nxt = RELEASE;
            RELEASE: begin
                if (!serviced_line)
                    state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change cleanly on the clock edge.
    always_ff @(posedge aes_clk or negedge aes_rst_n) begin
        if (!aes_rst_n) begin
            state              <= IDLE;
            addr_q             <= '0;
            data_q             <= '0;
            op_rd_q            <= 1'b0;
            cnt_q              <= 3'd0;
            aes_bram_read_data <= '0;
            bram_complete      <= 1'b0;
            bram_err           <= 1'b0;
            bram_en            <= 1'b0;
            bram_we            <= 4'h0;
        end else begin
            state         <= state_nxt;
            bram_en       <= (state_nxt == RD_ISSUE) || (state_nxt == WR_ISSUE);
            bram_we       <= (state_nxt == WR_ISSUE) ? 4'hF : 4'h0;
            bram_complete <= (state_nxt == DONE);
`ifdef AES_BRAM_ALIGN_CHECK_EN
            bram_err      <= (state == IDLE) && (state_nxt == DONE);
`else
            bram_err      <= 1'b0;
`endif
            if (state == IDLE && req) begin
                addr_q  <= cap_addr[BRAM_AW+1:2];
                op_rd_q <= aes_start_read;
                if (!aes_start_read)
                    data_q <= aes_bram_write_data;
            end

            if (state == RD_ISSUE)
                cnt_q <= CNT_LOAD;
            else if (state == RD_WAIT && cnt_q != 3'd0)
                cnt_q <= cnt_q - 3'd1;

            if (state == RD_WAIT && cnt_q == 3'd0)
                aes_bram_read_data <= bram_rddata;
        end
    end

endmodule

// File: tb/tb_aes_bram_responder.sv
// Directed bench for aes_bram_responder: transaction-level scoreboard plus a latency-accurate BRAM model.
module tb_aes_bram_responder;

    localparam int RL = 2;
    localparam int AW = 12;

    logic          aes_clk = 1'b0;
    logic          aes_rst_n = 1'b0;
    logic          aes_start_read = 1'b0;
    logic          aes_start_write = 1'b0;
    logic [31:0]   aes_bram_addr = '0;
    logic [31:0]   aes_bram_write_addr = '0;
    logic [31:0]   aes_bram_write_data = '0;
    logic [31:0]   aes_bram_read_data;
    logic          bram_complete;
    logic          bram_err;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic [AW-1:0] bram_word_addr;
    logic [31:0]   bram_wrdata;
    logic [31:0]   bram_rddata;

    aes_bram_responder #(.READ_LATENCY(RL), .BRAM_AW(AW)) dut (
        .aes_clk            (aes_clk),
        .aes_rst_n          (aes_rst_n),
        .aes_start_read     (aes_start_read),
        .aes_start_write    (aes_start_write),
        .aes_bram_addr      (aes_bram_addr),
        .aes_bram_write_addr(aes_bram_write_addr),
        .aes_bram_write_data(aes_bram_write_data),
        .aes_bram_read_data (aes_bram_read_data),
        .bram_complete      (bram_complete),
        .bram_err           (bram_err),
        .bram_en            (bram_en),
        .bram_we            (bram_we),
        .bram_word_addr     (bram_word_addr),
        .bram_wrdata        (bram_wrdata),
        .bram_rddata        (bram_rddata)
    );

    always #5 aes_clk = ~aes_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge aes_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // BRAM: samples en/addr on an edge, data valid RL edges later for exactly one cycle.
    bit   [31:0] mem [0:4095];
    logic [31:0] pipe [0:RL-1];
    assign bram_rddata = pipe[RL-1];

    always @(posedge aes_clk) begin
        if (bram_en && bram_we == 4'hF) mem[bram_word_addr] <= bram_wrdata;
        pipe[0] <= bram_en ? mem[bram_word_addr] : 32'h0BAD_0BAD;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    typedef struct {
        bit          rd;
        bit          misal;
        bit          check_lat;
        int          t0;
        int          lat;
        logic [11:0] word;
        logic [31:0] data;
    } txn_t;

    txn_t        q[$];
    bit   [31:0] gold [0:4095];

    function automatic logic [11:0] word_of(input logic [31:0] a);
        return 12'((a >> 2) % 4096);
    endfunction

    task automatic expect_txn(input bit rd, input logic [31:0] a, input logic [31:0] d,
                              input bit lat_chk, input bit misal);
        txn_t t;
        t.rd        = rd;
        t.misal     = misal;
        t.check_lat = lat_chk;
        t.t0        = cyc;
        t.word      = word_of(a);
        t.lat       = misal ? 1 : (rd ? RL + 2 : 2);
        if (rd) begin
            t.data = gold[t.word];
        end else begin
            t.data = d;
            if (!misal) gold[t.word] = d;
        end
        q.push_back(t);
    endtask

    // Scoreboard: one check per completion, invariants every active cycle.
    txn_t        cur;
    int          acc_cnt = 0;
    int          n_done  = 0;
    bit          prev_c  = 1'b0;
    logic [11:0] last_word = '0;
    logic [3:0]  last_we   = '0;
    logic [31:0] last_wd   = '0;
    logic [31:0] exp_rd    = '0;

    always @(negedge aes_clk) begin
        if (!aes_rst_n) begin
            q.delete();
            acc_cnt = 0;
            prev_c  = 1'b0;
            exp_rd  = '0;
        end else begin
            chk("we_gate", 32'(bram_we != 4'h0 && !bram_en), 32'd0);
            if (bram_en) begin
                acc_cnt++;
                last_word = bram_word_addr;
                last_we   = bram_we;
                last_wd   = bram_wrdata;
            end
            if (bram_complete) begin
                chk("complete_width", 32'(prev_c), 32'd0);
                chk("pending_txn", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    if (cur.check_lat) chk("latency", 32'(cyc - cur.t0), 32'(cur.lat));
                    chk("access_count", 32'(acc_cnt), cur.misal ? 32'd0 : 32'd1);
                    chk("err_flag", 32'(bram_err), 32'(cur.misal));
                    if (!cur.misal) begin
                        chk("access_word", 32'(last_word), 32'(cur.word));
                        chk("access_we", 32'(last_we), cur.rd ? 32'd0 : 32'hF);
                        if (!cur.rd) chk("write_data", last_wd, cur.data);
                        if (cur.rd) exp_rd = cur.data;
                    end
                    chk("read_data", aes_bram_read_data, exp_rd);
                end
                n_done++;
                acc_cnt = 0;
            end else begin
                chk("err_quiet", 32'(bram_err), 32'd0);
            end
            prev_c = bram_complete;
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 50 && n_done < target; i++) begin
            @(negedge aes_clk);
            #1;
        end
        chk("done_timeout", 32'(n_done >= target), 32'd1);
    endtask

    task automatic drop_all();
        @(posedge aes_clk);
        #1;
        aes_start_read  = 1'b0;
        aes_start_write = 1'b0;
    endtask

    task automatic raise_rd(input logic [31:0] a);
        @(posedge aes_clk);
        #1;
        aes_bram_addr  = a;
        aes_start_read = 1'b1;
        expect_txn(1'b1, a, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic raise_wr(input logic [31:0] a, input logic [31:0] d, input bit misal);
        @(posedge aes_clk);
        #1;
        aes_bram_write_addr = a;
        aes_bram_write_data = d;
        aes_start_write     = 1'b1;
        expect_txn(1'b0, a, d, 1'b1, misal);
    endtask

    task automatic do_read(input logic [31:0] a);
        int tgt;
        tgt = n_done + 1;
        raise_rd(a);
        wait_done(tgt);
        drop_all();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit misal);
        int tgt;
        tgt = n_done + 1;
        raise_wr(a, d, misal);
        wait_done(tgt);
        drop_all();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : driver
        int tgt;

        #1;
        chk("reset_read_data", aes_bram_read_data, 32'h0);
        chk("reset_complete", 32'(bram_complete), 32'd0);
        chk("reset_en", 32'(bram_en), 32'd0);
        chk("reset_we", 32'(bram_we), 32'd0);
        chk("reset_word_addr", 32'(bram_word_addr), 32'd0);
        chk("reset_err", 32'(bram_err), 32'd0);
        repeat (3) @(posedge aes_clk);
        #1;
        aes_rst_n = 1'b1;

        // Write then read the same word.
        do_write(32'h10, 32'hDEADBEEF, 1'b0);
        chk("first_write_word", 32'(last_word), 32'd4);
        chk("first_write_we", 32'(last_we), 32'hF);
        do_read(32'h10);
        chk("first_read_value", aes_bram_read_data, 32'hDEADBEEF);

        // Held request is serviced once; one low cycle re-arms.
        tgt = n_done + 1;
        raise_rd(32'h10);
        wait_done(tgt);
        repeat (10) @(posedge aes_clk);
        #1;
        chk("hold_accesses", 32'(acc_cnt), 32'd0);
        chk("hold_completes", 32'(n_done), 32'(tgt));
        drop_all();
        do_read(32'h10);

        // Simultaneous requests: read first, write after the read line drops.
        tgt = n_done;
        @(posedge aes_clk);
        #1;
        aes_bram_addr       = 32'h0;
        aes_bram_write_addr = 32'h4;
        aes_bram_write_data = 32'h1;
        aes_start_read      = 1'b1;
        aes_start_write     = 1'b1;
        expect_txn(1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        expect_txn(1'b0, 32'h4, 32'h1, 1'b0, 1'b0);
        wait_done(tgt + 1);
        @(posedge aes_clk);
        #1;
        aes_start_read = 1'b0;
        wait_done(tgt + 2);
        drop_all();
        do_read(32'h4);
        chk("pending_write_value", aes_bram_read_data, 32'h1);

        // Reset during RD_WAIT aborts the read.
        raise_rd(32'h10);
        @(posedge aes_clk);
        @(posedge aes_clk);
        #2;
        aes_rst_n = 1'b0;
        #1;
        chk("abort_en", 32'(bram_en), 32'd0);
        chk("abort_complete", 32'(bram_complete), 32'd0);
        chk("abort_read_data", aes_bram_read_data, 32'h0);
        aes_start_read = 1'b0;
        repeat (2) @(posedge aes_clk);
        #1;
        aes_rst_n = 1'b1;
        do_read(32'h10);
        chk("post_reset_read", aes_bram_read_data, 32'hDEADBEEF);

        // Address wrap and top word.
        do_write(32'hFFFF_FFFC, 32'h1234_5678, 1'b0);
        do_read(32'h0000_3FFC);
        chk("top_word_read", aes_bram_read_data, 32'h1234_5678);
        do_read(32'h0000_4010);
        chk("wrap_read", aes_bram_read_data, 32'hDEADBEEF);

        // Misaligned write.
`ifdef AES_BRAM_ALIGN_CHECK_EN
        do_write(32'h13, 32'hCAFE_F00D, 1'b1);
        do_read(32'h10);
        chk("misaligned_skipped", aes_bram_read_data, 32'hDEADBEEF);
`else
        do_write(32'h13, 32'hCAFE_F00D, 1'b0);
        chk("misaligned_word", 32'(last_word), 32'd4);
        do_read(32'h10);
        chk("misaligned_landed", aes_bram_read_data, 32'hCAFE_F00D);
`endif

        repeat (3) @(posedge aes_clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
